// File: rtl/lut_loader_if.sv
// Load stream, status and asynchronous read port of the writable LUT.
interface lut_loader_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 64
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic             start;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic             loaded;
  logic [AW:0]      wr_count;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] data;

  modport master (
    output start, in_valid, in_data, addr,
    input  in_ready, busy, done, loaded, wr_count, data
  );

  modport slave (
    input  start, in_valid, in_data, addr,
    output in_ready, busy, done, loaded, wr_count, data
  );
endinterface

// File: rtl/lut_loader.sv
// Run-time loadable DEPTH x WIDTH lookup table: filled from a valid/ready word
// stream, read through a zero-latency combinational port.
module lut_loader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  lut_loader_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t           state;
  logic [AW-1:0]    ptr;
  logic [AW:0]      wr_count;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic             loaded;
  logic             wr_en;
  logic [WIDTH-1:0] mem [DEPTH];

  // in_ready is only ever high in LOAD, so it alone qualifies the handshake
  assign wr_en = in_ready & bus.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      wr_count <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      loaded   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            state    <= LOAD;
            ptr      <= '0;
            wr_count <= '0;
            loaded   <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (wr_en) begin
            if (ptr == AW'(DEPTH - 1)) begin
              // last entry: pointer holds, no wrap into address 0
              state    <= DONE;
              wr_count <= (AW + 1)'(DEPTH);
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              loaded   <= 1'b1;
            end else begin
              ptr      <= ptr + AW'(1);
              wr_count <= wr_count + (AW + 1)'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  // Table storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr] <= bus.in_data;
  end

  assign bus.in_ready = in_ready;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.loaded   = loaded;
  assign bus.wr_count = wr_count;
  assign bus.data     = mem[bus.addr];
endmodule
